wb_stage: RTL and testbench

Write-back stage of the core_lapido pipeline. Latches the MEM/WB pipeline register and selects the result: ALU, load data, link PC, or LCL/LCH constant merge. Drives the register_file write port (`en`, `rd`, `data`) and a forwarding tap. After every reset it runs a clear sequence that zeroes all general-purpose registers, and holds the pipeline stalled until that sequence finishes.

---
 rtl/wb_stage.sv | 121 ++++++++++++
 tb/tb_wb_stage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Write-back stage: latches MEM/WB, selects the result and drives the register_file write port.
// After reset it clears every GPR before letting the pipeline run.
module wb_stage #(
  parameter int unsigned GPR_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_reg_write_enable,
  input  logic [1:0]            in_wb_res_mux,
  input  logic                  in_lc_high,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [GPR_WIDTH-1:0]  in_alu_result,
  input  logic [GPR_WIDTH-1:0]  in_mem_data,
  input  logic [PC_WIDTH-1:0]   in_next_pc,
  input  logic [GPR_WIDTH-1:0]  in_imm,
  input  logic [GPR_WIDTH-1:0]  in_rd_old,
  output logic                  reg_en,
  output logic [ADDR_WIDTH-1:0] reg_rd,
  output logic [GPR_WIDTH-1:0]  reg_data,
  output logic                  init_busy,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_rd,
  output logic [GPR_WIDTH-1:0]  fwd_data,
  output logic [31:0]           retired_count
);

  typedef enum logic {S_INIT = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [GPR_WIDTH-1:0]  LO_MASK  = GPR_WIDTH'(32'h0000_FFFF);
  // Upper half of a 32-bit word; narrower GPRs keep only the bits that exist.
  localparam logic [GPR_WIDTH-1:0]  HI_MASK  = GPR_WIDTH'(32'hFFFF_0000);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  reg_en_q, reg_en_d;
  logic [ADDR_WIDTH-1:0] reg_rd_q, reg_rd_d;
  logic [GPR_WIDTH-1:0]  reg_data_q, reg_data_d;
  logic                  busy_q, busy_d;
  logic [31:0]           retired_q, retired_d;
  logic [GPR_WIDTH-1:0]  result_c;
  logic [GPR_WIDTH-1:0]  lcl_c, lch_c;

  assign lcl_c = (in_rd_old & ~LO_MASK) | (in_imm & LO_MASK);
  assign lch_c = (in_rd_old & ~HI_MASK) | ((in_imm << 16) & HI_MASK);

  always_comb begin
    result_c = in_alu_result;
    unique case (in_wb_res_mux)
      2'b00:   result_c = in_alu_result;
      2'b01:   result_c = in_mem_data;
      2'b10:   result_c = GPR_WIDTH'(in_next_pc);
      default: result_c = in_lc_high ? lch_c : lcl_c;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_INIT && cnt_q == LAST_IDX) state_d = S_RUN;
  end

  // INIT walks the clear counter; RUN forwards the selected result.
  always_comb begin
    cnt_d      = cnt_q;
    reg_en_d   = reg_en_q;
    reg_rd_d   = reg_rd_q;
    reg_data_d = reg_data_q;
    busy_d     = busy_q;
    retired_d  = retired_q;
    if (state_q == S_INIT) begin
      reg_en_d   = 1'b1;
      reg_rd_d   = cnt_q;
      reg_data_d = '0;
      cnt_d      = (cnt_q == LAST_IDX) ? '0 : cnt_q + ADDR_WIDTH'(1);
      busy_d     = (cnt_q != LAST_IDX);
    end else begin
      reg_en_d   = in_valid & in_reg_write_enable;
      reg_rd_d   = in_rd;
      reg_data_d = result_c;
      busy_d     = 1'b0;
      retired_d  = retired_q + 32'(in_valid);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      reg_en_q   <= 1'b0;
      reg_rd_q   <= '0;
      reg_data_q <= '0;
      busy_q     <= 1'b1;
      retired_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      reg_en_q   <= reg_en_d;
      reg_rd_q   <= reg_rd_d;
      reg_data_q <= reg_data_d;
      busy_q     <= busy_d;
      retired_q  <= retired_d;
    end
  end

  assign reg_en        = reg_en_q;
  assign reg_rd        = reg_rd_q;
  assign reg_data      = reg_data_q;
  assign init_busy     = busy_q;
  assign retired_count = retired_q;
  assign fwd_valid     = reg_en_q & ~busy_q;
  assign fwd_rd        = reg_rd_q;
  assign fwd_data      = reg_data_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: clear sequence, result select table,
// random traffic against a register-file reference, and reset corner cases.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_reg_write_enable, in_lc_high;
  logic [1:0]  in_wb_res_mux;
  logic [4:0]  in_rd;
  logic [31:0] in_alu_result, in_mem_data, in_next_pc, in_imm, in_rd_old;
  logic        reg_en, init_busy, fwd_valid;
  logic [4:0]  reg_rd, fwd_rd;
  logic [31:0] reg_data, fwd_data, retired_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];
  logic        preload = 1'b0;
  logic [31:0] exp_ret;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_reg_write_enable(in_reg_write_enable),
    .in_wb_res_mux(in_wb_res_mux), .in_lc_high(in_lc_high), .in_rd(in_rd),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data),
    .in_next_pc(in_next_pc), .in_imm(in_imm), .in_rd_old(in_rd_old),
    .reg_en(reg_en), .reg_rd(reg_rd), .reg_data(reg_data),
    .init_busy(init_busy), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Register file reference: commits the write port one edge after it is presented.
  always @(posedge clk) begin
    if (preload) begin
      rf[5]  <= 32'd5;
      rf[15] <= 32'd15;
    end else if (reg_en) begin
      rf[reg_rd] <= reg_data;
    end
  end

  typedef struct {
    logic        valid, we, lch;
    logic [1:0]  mux;
    logic [4:0]  rd;
    logic [31:0] alu, mem, npc, imm, old;
    logic        exp_en;
    logic [31:0] exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_res(input logic [1:0] mux, input logic lch,
      input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] npc,
      input logic [31:0] imm, input logic [31:0] old);
    case (mux)
      2'd0: return alu;
      2'd1: return mem;
      2'd2: return npc;
      default: return lch ? (((imm % 32'h1_0000) * 32'h1_0000) + (old % 32'h1_0000))
                          : ((old / 32'h1_0000) * 32'h1_0000 + (imm % 32'h1_0000));
    endcase
  endfunction

  task automatic drive(input logic v, input logic we, input logic [1:0] mux, input logic lch,
      input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mem,
      input logic [31:0] npc, input logic [31:0] imm, input logic [31:0] old);
    in_valid = v; in_reg_write_enable = we; in_wb_res_mux = mux; in_lc_high = lch;
    in_rd = rd; in_alu_result = alu; in_mem_data = mem; in_next_pc = npc;
    in_imm = imm; in_rd_old = old;
  endtask

  task automatic drive_random();
    drive(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 5'($urandom),
          $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  // Walk the clear sequence with junk on the inputs; steps are counted from rst release.
  task automatic run_init(input int stop_after);
    for (int k = 0; k < 32 && k < stop_after; k++) begin
      drive_random();
      step();
      chk("init_rd", 32'(reg_rd), 32'(k));
      chk("init_en", 32'(reg_en), 32'd1);
      chk("init_data", reg_data, 32'd0);
      chk("init_busy", 32'(init_busy), (k < 31) ? 32'd1 : 32'd0);
      chk("init_fwd_valid", 32'(fwd_valid), (k < 31) ? 32'd0 : 32'd1);
    end
    chk("init_retired", retired_count, 32'd0);
  endtask

  vec_t vecs [7];

  initial begin
    vecs[0] = '{1, 1, 0, 2'd0, 5'd7, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'h1234_5678};
    vecs[1] = '{1, 1, 0, 2'd3, 5'd3, 32'h0, 32'h0, 32'h0, 32'h0000_1234, 32'hAAAA_BBBB, 1, 32'hAAAA_1234};
    vecs[2] = '{1, 1, 1, 2'd3, 5'd4, 32'h0, 32'h0, 32'h0, 32'hFFFF_1234, 32'hAAAA_BBBB, 1, 32'h1234_BBBB};
    vecs[3] = '{1, 1, 0, 2'd2, 5'd1, 32'h0, 32'h0, 32'h0000_002A, 32'h0, 32'h0, 1, 32'h0000_002A};
    vecs[4] = '{1, 1, 0, 2'd1, 5'd9, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 1, 32'hDEAD_BEEF};
    vecs[5] = '{1, 1, 0, 2'd0, 5'd0, 32'h0000_0055, 32'h0, 32'h0, 32'h0, 32'h0, 1, 32'h0000_0055};
    vecs[6] = '{1, 0, 0, 2'd0, 5'd4, 32'h0000_0099, 32'h0, 32'h0, 32'h0, 32'h0, 0, 32'h0000_0099};

    rst = 1'b1;
    drive(0, 0, 2'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_en", 32'(reg_en), 32'd0);
    chk("rst_rd", 32'(reg_rd), 32'd0);
    chk("rst_data", reg_data, 32'd0);
    chk("rst_busy", 32'(init_busy), 32'd1);
    chk("rst_retired", retired_count, 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);

    for (int i = 0; i < 32; i++) rf[i] = 32'hFFFF_FFFF;
    preload = 1'b1;
    step();
    preload = 1'b0;
    step();
    chk("rst_held_en", 32'(reg_en), 32'd0);
    chk("preload_r5", rf[5], 32'd5);
    rst = 1'b0;
    run_init(32);
    drive(0, 0, 2'd0, 0, 5'd0, 0, 0, 0, 0, 0);
    step();
    for (int i = 0; i < 32; i++) chk($sformatf("cleared_r%0d", i), rf[i], 32'd0);
    chk("busy_after_init", 32'(init_busy), 32'd0);
    exp_ret = 32'd0;

    // Result-select table
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].valid, vecs[i].we, vecs[i].mux, vecs[i].lch, vecs[i].rd,
            vecs[i].alu, vecs[i].mem, vecs[i].npc, vecs[i].imm, vecs[i].old);
      step();
      exp_ret += 32'(vecs[i].valid);
      chk($sformatf("vec%0d_en", i), 32'(reg_en), 32'(vecs[i].exp_en));
      chk($sformatf("vec%0d_rd", i), 32'(reg_rd), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_data", i), reg_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_fwd_valid", i), 32'(fwd_valid), 32'(vecs[i].exp_en));
      chk($sformatf("vec%0d_fwd_rd", i), 32'(fwd_rd), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_fwd_data", i), fwd_data, vecs[i].exp_data);
      if (i > 0 && vecs[i-1].exp_en)
        chk($sformatf("vec%0d_commit", i - 1), rf[vecs[i-1].rd], vecs[i-1].exp_data);
      chk($sformatf("vec%0d_retired", i), retired_count, exp_ret);
    end
    chk("r4_not_written", rf[4], 32'h1234_BBBB);

    // valid/we=1, bubble, valid/we=0, valid/we=1
    begin
      logic [31:0] base;
      logic [3:0]  seq_v, seq_w, exp_en;
      base = retired_count;
      seq_v = 4'b1011; seq_w = 4'b1001; exp_en = 4'b1001;
      for (int i = 0; i < 4; i++) begin
        drive(seq_v[3-i], seq_w[3-i], 2'd0, 0, 5'd12, 32'(i), 0, 0, 0, 0);
        step();
        chk($sformatf("seq%0d_en", i), 32'(reg_en), 32'(exp_en[3-i]));
      end
      chk("seq_retired", retired_count - base, 32'd3);
      exp_ret = retired_count;
    end

    // Random traffic; rd limited to a few registers to exercise back-to-back writes.
    begin
      logic        prev_en;
      logic [4:0]  prev_rd;
      logic [31:0] prev_data;
      logic        e_en;
      logic [31:0] e_data;
      prev_en = 1'b0; prev_rd = '0; prev_data = '0;
      for (int n = 0; n < 300; n++) begin
        drive_random();
        in_rd = 5'($urandom_range(0, 3));
        e_en = in_valid & in_reg_write_enable;
        e_data = model_res(in_wb_res_mux, in_lc_high, in_alu_result, in_mem_data,
                           in_next_pc, in_imm, in_rd_old);
        exp_ret += 32'(in_valid);
        step();
        chk("rnd_en", 32'(reg_en), 32'(e_en));
        chk("rnd_rd", 32'(reg_rd), 32'(in_rd));
        if (e_en) chk("rnd_data", reg_data, e_data);
        chk("rnd_fwd_valid", 32'(fwd_valid), 32'(e_en));
        if (prev_en) chk("rnd_commit", rf[prev_rd], prev_data);
        chk("rnd_retired", retired_count, exp_ret);
        prev_en = e_en; prev_rd = in_rd; prev_data = e_data;
      end
    end

    // Reset mid-INIT
    rst = 1'b1;
    #1;
    chk("run_rst_retired", retired_count, 32'd0);
    chk("run_rst_busy", 32'(init_busy), 32'd1);
    step();
    rst = 1'b0;
    run_init(10);
    drive(1, 1, 2'd0, 0, 5'd20, 32'hCAFE_0000, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("midinit_rst_en", 32'(reg_en), 32'd0);
    chk("midinit_rst_rd", 32'(reg_rd), 32'd0);
    chk("midinit_rst_busy", 32'(init_busy), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_held_no_write", 32'(reg_en), 32'd0);
    end
    rst = 1'b0;
    run_init(32);
    drive(1, 1, 2'd0, 0, 5'd20, 32'h0BAD_F00D, 0, 0, 0, 0);
    step();
    chk("post_reinit_data", reg_data, 32'h0BAD_F00D);
    chk("post_reinit_retired", retired_count, 32'd1);
    step();
    chk("post_reinit_commit", rf[20], 32'h0BAD_F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
